// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MIPS MEM stage.
// It serves one word-addressed load or store at a time. A fixed number of wait
// states follows each request, and completion is marked by a one-cycle
// resp_valid pulse.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        p_clk,
  input  logic        p_rst_s,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_valid;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH];

  logic               w_sel_in;
  logic               w_we;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [3:0]         w_be;
  logic               w_err;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_fire;
  logic               w_wr_en;

  // Choose the access operands. With zero wait states the access happens in the
  // accept cycle, before the latched copy exists, so the live inputs are used.
  always_comb begin
    w_sel_in = (r_state == S_IDLE);
    w_we     = w_sel_in ? req_we    : r_we;
    w_addr   = w_sel_in ? req_addr  : r_addr;
    w_wdata  = w_sel_in ? req_wdata : r_wdata;
    w_be     = w_sel_in ? req_be    : r_be;
    w_err    = (w_addr[1:0] != 2'b00) || ((w_addr >> (ADDR_W + 2)) != 32'd0);
    w_idx    = w_addr[ADDR_W+1:2];
    w_fire   = (w_sel_in && req_valid && (WAIT_CYCLES == 0)) ||
               ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));
    w_wr_en  = w_fire && w_we && !w_err;
    mem_stall = ((r_state == S_IDLE) && req_valid) || (r_state == S_WAIT);
  end

  // RAM write with per-lane byte enables. The RAM itself is not reset.
  always_ff @(posedge p_clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM, request latch and registered response.
  always_ff @(posedge p_clk or negedge p_rst_s) begin
    if (!p_rst_s) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_fire) begin
        r_valid <= 1'b1;
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign addr_err   = r_err;

endmodule
